_gcd_stein: RTL and testbench

- Parametrised GCD engine; successor to the 8-bit search-down GCD.
- Computes gcd(_num0, _num1) with the binary (Stein) algorithm, so iterations are O(WIDTH), not O(value).
- Explicit start/busy/done handshake, defined zero-operand behaviour and a coprime flag.
- Sits as an arithmetic leaf block, used by number-theory examples and the ratio/clock-divider helpers.

---
 rtl/_gcd_stein.sv | 100 ++++++++++
 tb/tb__gcd_stein.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/_gcd_stein.sv
// Binary (Stein) GCD engine with start/busy/done handshake and a coprime flag.
// The number of iterations grows with WIDTH rather than with operand magnitude.
module _gcd_stein #(
  parameter int WIDTH = 8
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic [WIDTH-1:0] _num0,
  input  logic [WIDTH-1:0] _num1,
  output logic             _busy,
  output logic             _done,
  output logic [WIDTH-1:0] _greatest,
  output logic             _coprime
);

  localparam int KW = $clog2(WIDTH + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] STRIP = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] scaled;

  // The result never exceeds the smaller operand, so restoring the common
  // powers of two cannot overflow WIDTH bits.
  assign scaled = a << k;

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      k        <= '0;
      _greatest <= '0;
      _coprime  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (_start) begin
            if (_num0 == '0 || _num1 == '0) begin
              _greatest <= _num0 | _num1;
              _coprime  <= (_num0 | _num1) == WIDTH'(1);
              state     <= DONE;
            end else begin
              a     <= _num0;
              b     <= _num1;
              k     <= '0;
              state <= STRIP;
            end
          end
        end
        STRIP: begin
          if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          // Subtraction branches only run with both values odd, so the
          // difference is even and the shift drops no information.
          if (a == b)
            state <= SHIFT;
          else if (!a[0])
            a <= a >> 1;
          else if (!b[0])
            b <= b >> 1;
          else if (a > b)
            a <= (a - b) >> 1;
          else
            b <= (b - a) >> 1;
        end
        SHIFT: begin
          _greatest <= scaled;
          _coprime  <= scaled == WIDTH'(1);
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign _busy = state != IDLE;
  assign _done = state == DONE;

endmodule

// File: tb/tb__gcd_stein.sv
// Bench for _gcd_stein: an 8-bit and a 16-bit instance share one clock/reset,
// checked each cycle against a Euclid-based model plus literal expectations.
module tb__gcd_stein;

  logic        clock;
  logic        reset;
  logic        start_i [2];
  logic [31:0] n0_i [2];
  logic [31:0] n1_i [2];

  logic        busy8, done8, cop8;
  logic [7:0]  great8;
  logic        busy16, done16, cop16;
  logic [15:0] great16;

  logic        busy_o [2];
  logic        done_o [2];
  logic        cop_o [2];
  logic [31:0] great_o [2];

  int tests = 0;
  int fails = 0;
  int last_lat = 0;

  logic [31:0] held_g [2];
  logic        held_c [2];
  logic [31:0] exp_g [2];
  bit          pend [2];
  bit          zero_path [2];
  bit          was_pend [2];
  int          cyc [2];
  bit          chk_en = 0;

  _gcd_stein #(.WIDTH(8)) dut8 (
    ._clock(clock), ._reset(reset), ._start(start_i[0]),
    ._num0(n0_i[0][7:0]), ._num1(n1_i[0][7:0]),
    ._busy(busy8), ._done(done8), ._greatest(great8), ._coprime(cop8)
  );

  _gcd_stein #(.WIDTH(16)) dut16 (
    ._clock(clock), ._reset(reset), ._start(start_i[1]),
    ._num0(n0_i[1][15:0]), ._num1(n1_i[1][15:0]),
    ._busy(busy16), ._done(done16), ._greatest(great16), ._coprime(cop16)
  );

  assign busy_o[0]  = busy8;
  assign done_o[0]  = done8;
  assign cop_o[0]   = cop8;
  assign great_o[0] = {24'd0, great8};
  assign busy_o[1]  = busy16;
  assign done_o[1]  = done16;
  assign cop_o[1]   = cop16;
  assign great_o[1] = {16'd0, great16};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int bound_of(input int s);
    return (s == 0) ? 20 : 36;
  endfunction

  function automatic logic [31:0] mask_of(input int s, input logic [31:0] v);
    return (s == 0) ? (v & 32'hFF) : (v & 32'hFFFF);
  endfunction

  // Reference GCD by Euclid's remainder method, independent of Stein's steps.
  function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endfunction

  // Cycle-level model: tracks which instance owes a result, what it must be,
  // and the value the outputs must hold while no completion is due.
  always @(negedge clock) begin
    for (int s = 0; s < 2; s++) begin
      was_pend[s] = pend[s];
      if (chk_en) begin
        if (pend[s]) begin
          cyc[s]++;
          checkOutput(s == 0 ? "busy8_active" : "busy16_active", {31'd0, busy_o[s]}, 32'd1);
          if (done_o[s]) begin
            checkOutput(s == 0 ? "model8_result" : "model16_result", great_o[s], exp_g[s]);
            checkOutput(s == 0 ? "model8_coprime" : "model16_coprime", {31'd0, cop_o[s]},
                        {31'd0, exp_g[s] == 32'd1});
            if (zero_path[s])
              checkOutput("zero_path_latency", cyc[s], 32'd1);
            else
              checkOutput("latency_within_bound", {31'd0, cyc[s] <= bound_of(s)}, 32'd1);
            held_g[s] = exp_g[s];
            held_c[s] = exp_g[s] == 32'd1;
            pend[s] = 0;
          end else begin
            checkOutput("hold_greatest_busy", great_o[s], held_g[s]);
            checkOutput("hold_coprime_busy", {31'd0, cop_o[s]}, {31'd0, held_c[s]});
            if (cyc[s] > bound_of(s)) begin
              checkOutput("done_within_bound", cyc[s], bound_of(s));
              pend[s] = 0;
            end
          end
        end else begin
          checkOutput(s == 0 ? "busy8_idle" : "busy16_idle", {31'd0, busy_o[s]}, 32'd0);
          checkOutput(s == 0 ? "done8_idle" : "done16_idle", {31'd0, done_o[s]}, 32'd0);
          checkOutput("hold_greatest_idle", great_o[s], held_g[s]);
          checkOutput("hold_coprime_idle", {31'd0, cop_o[s]}, {31'd0, held_c[s]});
        end
      end
      if (reset) begin
        pend[s]   = 0;
        held_g[s] = 0;
        held_c[s] = 0;
      end else if (start_i[s] && !was_pend[s]) begin
        pend[s]      = 1;
        cyc[s]       = 0;
        exp_g[s]     = ref_gcd(mask_of(s, n0_i[s]), mask_of(s, n1_i[s]));
        zero_path[s] = (mask_of(s, n0_i[s]) == 0) || (mask_of(s, n1_i[s]) == 0);
      end
    end
    if (reset) chk_en = 1;
  end

  // Launch one operation and wait (bounded) for completion. With poke set,
  // extra starts are raised mid-run and during the DONE cycle; both must be ignored.
  task automatic applyStimulus(input int s, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] exp_res, input logic exp_cop, input bit poke);
    bit got;
    got = 0;
    @(posedge clock); #1;
    n0_i[s] = x;
    n1_i[s] = y;
    start_i[s] = 1'b1;
    @(posedge clock); #1;
    start_i[s] = 1'b0;
    n0_i[s] = $urandom;
    n1_i[s] = $urandom;
    for (int i = 1; i <= bound_of(s) + 2 && !got; i++) begin
      @(negedge clock);
      if (done_o[s]) begin
        got = 1;
        last_lat = i;
        checkOutput("greatest", great_o[s], exp_res);
        checkOutput("coprime", {31'd0, cop_o[s]}, {31'd0, exp_cop});
        if (poke) begin
          #1 start_i[s] = 1'b1;
          @(posedge clock); #1;
          start_i[s] = 1'b0;
        end
      end else if (poke && i == 2) begin
        #1 start_i[s] = 1'b1;
        @(posedge clock); #1;
        start_i[s] = 1'b0;
      end
    end
    checkOutput("done_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    logic [31:0] x, y, g;
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start_i[s] = 1'b0;
      n0_i[s] = 0;
      n1_i[s] = 0;
      pend[s] = 0;
      held_g[s] = 0;
      held_c[s] = 0;
      cyc[s] = 0;
    end

    // Reset, then a quiet interval with start low.
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_busy", {31'd0, busy8}, 32'd0);
    checkOutput("reset_done", {31'd0, done8}, 32'd0);
    checkOutput("reset_greatest", {24'd0, great8}, 32'd0);
    checkOutput("reset_coprime", {31'd0, cop8}, 32'd0);
    repeat (10) @(posedge clock);

    applyStimulus(0, 12, 18, 6, 1'b0, 0);
    checkOutput("latency_12_18", last_lat, 32'd7);

    applyStimulus(0, 0, 45, 45, 1'b0, 0);
    checkOutput("latency_zero", last_lat, 32'd1);
    applyStimulus(0, 0, 0, 0, 1'b0, 0);
    applyStimulus(0, 45, 0, 45, 1'b0, 1);
    applyStimulus(0, 1, 0, 1, 1'b1, 0);

    applyStimulus(0, 255, 255, 255, 1'b0, 1);
    applyStimulus(0, 255, 254, 1, 1'b1, 1);
    applyStimulus(0, 128, 64, 64, 1'b0, 1);
    applyStimulus(0, 1, 255, 1, 1'b1, 0);
    applyStimulus(0, 200, 150, 50, 1'b0, 0);

    applyStimulus(1, 65535, 4369, 4369, 1'b0, 0);
    applyStimulus(1, 48000, 36000, 12000, 1'b0, 1);
    applyStimulus(1, 65521, 65519, 1, 1'b1, 0);
    applyStimulus(1, 32768, 32768, 32768, 1'b0, 0);

    for (int n = 0; n < 1000; n++) begin
      x = $urandom_range(0, 65535);
      y = $urandom_range(0, 65535);
      if (n % 50 == 0) y = 0;
      if (n % 7 == 0) y = x * $urandom_range(1, 3) & 32'hFFFF;
      g = ref_gcd(x, y);
      applyStimulus(1, x, y, g, g == 32'd1, n % 100 == 0);
    end

    // Abort mid-operation: reset in cycle 3 after the accepting edge.
    @(posedge clock); #1;
    n0_i[0] = 200;
    n1_i[0] = 150;
    start_i[0] = 1'b1;
    @(posedge clock); #1;
    start_i[0] = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("abort_busy", {31'd0, busy8}, 32'd0);
    checkOutput("abort_done", {31'd0, done8}, 32'd0);
    checkOutput("abort_greatest", {24'd0, great8}, 32'd0);
    checkOutput("abort_coprime", {31'd0, cop8}, 32'd0);
    repeat (25) @(posedge clock);
    applyStimulus(0, 200, 150, 50, 1'b0, 0);

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
